// File: rtl/iommu_iotlb.sv
`default_nettype none
// ============================================================================
// Module      : iommu_iotlb
// Description : Fully associative IO translation lookaside buffer with true
//               LRU replacement. Answers same-cycle lookups, accepts fills
//               from the page-table walker, and supports flush-all and
//               flush-by-VPN invalidation.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   tlb_query_valid/vaddr  lookup request
//   tlb_hit, tlb_paddr     combinational lookup response
//   tlb_update_valid/...   fill (VA's VPN -> PA's PPN)
//   flush_all              invalidate all entries
//   flush_vpn_valid/vpn    invalidate the entry holding flush_vpn
//   occupancy              registered count of valid entries
// Optional (macro IOTLB_STATS_EN):
//   stats_clear            synchronous clear of the statistics counters
//   hit_count, miss_count, fill_count  saturating statistics counters
// ============================================================================
module iommu_iotlb #(
  parameter int ENTRIES   = 8,
  parameter int PAGE_BITS = 12,
  parameter int CNT_W     = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tlb_query_valid,
  input  logic [31:0]              tlb_query_vaddr,
  output logic                     tlb_hit,
  output logic [31:0]              tlb_paddr,
  input  logic                     tlb_update_valid,
  input  logic [31:0]              tlb_update_vaddr,
  input  logic [31:0]              tlb_update_paddr,
  input  logic                     flush_all,
  input  logic                     flush_vpn_valid,
  input  logic [31-PAGE_BITS:0]    flush_vpn,
  output logic [$clog2(ENTRIES):0] occupancy
`ifdef IOTLB_STATS_EN
  ,
  input  logic                     stats_clear,
  output logic [CNT_W-1:0]         hit_count,
  output logic [CNT_W-1:0]         miss_count,
  output logic [CNT_W-1:0]         fill_count
`endif
);

  localparam int VPN_W = 32 - PAGE_BITS;
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LRU_AGE = IDX_W'(ENTRIES - 1);

  typedef logic [ENTRIES-1:0][IDX_W-1:0] age_vec_t;

  // --------------------------------------------------------------------------
  // Entry storage
  // --------------------------------------------------------------------------
  logic [ENTRIES-1:0]            r_valid;
  logic [ENTRIES-1:0][VPN_W-1:0] r_vpn;
  logic [ENTRIES-1:0][VPN_W-1:0] r_ppn;
  age_vec_t                      r_age;
  logic [OCC_W-1:0]              r_occ;

  // Move entry idx to MRU: everything younger than it ages by one, so the
  // age vector stays a permutation of 0..ENTRIES-1.
  function automatic age_vec_t f_touch(input age_vec_t ages,
                                       input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] pivot;
    age_vec_t         res;
    pivot = ages[idx];
    res   = ages;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ages[i] < pivot) res[i] = ages[i] + 1'b1;
    end
    res[idx] = '0;
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // Lookup (zero latency, registered state only)
  // --------------------------------------------------------------------------
  logic [VPN_W-1:0]   w_q_vpn;
  logic [ENTRIES-1:0] w_q_match;
  logic [IDX_W-1:0]   w_q_idx;

  assign w_q_vpn = tlb_query_vaddr[31:PAGE_BITS];

  // No duplicates exist, so at most one bit of w_q_match is set.
  always_comb begin
    w_q_match = '0;
    w_q_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_q_match[i] = r_valid[i] && (r_vpn[i] == w_q_vpn);
      if (w_q_match[i]) w_q_idx = IDX_W'(i);
    end
  end

  assign tlb_hit   = tlb_query_valid && (|w_q_match);
  assign tlb_paddr = tlb_hit ? {r_ppn[w_q_idx], tlb_query_vaddr[PAGE_BITS-1:0]}
                             : 32'h0;

  // --------------------------------------------------------------------------
  // Flush-by-VPN, applied ahead of any same-cycle fill
  // --------------------------------------------------------------------------
  logic [ENTRIES-1:0] w_f_match;
  logic [ENTRIES-1:0] w_valid_pf;
  logic               w_f_any;

  always_comb begin
    w_f_match = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_f_match[i] = flush_vpn_valid && r_valid[i] && (r_vpn[i] == flush_vpn);
    end
  end

  assign w_f_any    = |w_f_match;
  assign w_valid_pf = r_valid & ~w_f_match;

  // --------------------------------------------------------------------------
  // Fill victim selection
  // --------------------------------------------------------------------------
  logic             w_fill;
  logic             w_hit_touch;
  logic [VPN_W-1:0] w_u_vpn;
  logic [VPN_W-1:0] w_u_ppn;
  logic             w_u_match_any;
  logic [IDX_W-1:0] w_u_match_idx;
  logic             w_free_any;
  logic [IDX_W-1:0] w_free_idx;
  logic [IDX_W-1:0] w_lru_idx;
  logic [IDX_W-1:0] w_victim;
  logic             w_fill_new;
  age_vec_t         w_age_t1;
  age_vec_t         w_age_nxt;

  // flush_all drops both the fill and any query touch.
  assign w_fill      = tlb_update_valid && !flush_all;
  assign w_hit_touch = tlb_hit && !flush_all;
  assign w_u_vpn     = tlb_update_vaddr[31:PAGE_BITS];
  assign w_u_ppn     = tlb_update_paddr[31:PAGE_BITS];

  // The hit touch goes first, so the LRU victim is chosen from ages that
  // already reflect this cycle's hit.
  assign w_age_t1 = w_hit_touch ? f_touch(r_age, w_q_idx) : r_age;

  always_comb begin
    w_u_match_any = 1'b0;
    w_u_match_idx = '0;
    w_free_any    = 1'b0;
    w_free_idx    = '0;
    w_lru_idx     = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_valid_pf[i] && (r_vpn[i] == w_u_vpn)) begin
        w_u_match_any = 1'b1;
        w_u_match_idx = IDX_W'(i);
      end
      if (w_age_t1[i] == LRU_AGE) w_lru_idx = IDX_W'(i);
    end
    // Scan downwards so the last assignment is the lowest free index.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!w_valid_pf[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_victim   = w_lru_idx;
    w_fill_new = 1'b0;
    if (w_u_match_any) begin
      w_victim = w_u_match_idx;
    end else if (w_free_any) begin
      w_victim   = w_free_idx;
      w_fill_new = 1'b1;
    end
  end

  // Touching the same entry twice is idempotent, so a fill that overwrites
  // the hit entry naturally gets a single touch.
  assign w_age_nxt = w_fill ? f_touch(w_age_t1, w_victim) : w_age_t1;

  // --------------------------------------------------------------------------
  // Next valid vector and occupancy
  // --------------------------------------------------------------------------
  logic [ENTRIES-1:0] w_valid_nxt;
  logic [OCC_W-1:0]   w_occ_nxt;

  always_comb begin
    w_valid_nxt = w_valid_pf;
    if (flush_all) begin
      w_valid_nxt = '0;
    end else if (w_fill) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_victim == IDX_W'(i)) w_valid_nxt[i] = 1'b1;
      end
    end
  end

  always_comb begin
    if (flush_all) begin
      w_occ_nxt = '0;
    end else begin
      w_occ_nxt = r_occ - OCC_W'(w_f_any) + OCC_W'(w_fill && w_fill_new);
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      r_occ   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_age[i] <= IDX_W'(i);
      end
    end else begin
      r_valid <= w_valid_nxt;
      r_occ   <= w_occ_nxt;
      r_age   <= w_age_nxt;
    end
  end

  // Tag/data arrays carry no reset; valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_vpn[w_victim] <= w_u_vpn;
      r_ppn[w_victim] <= w_u_ppn;
    end
  end

  assign occupancy = r_occ;

  // Page-offset bits of fill addresses carry no information for the TLB.
  logic w_unused_bits;
  assign w_unused_bits = ^{tlb_update_vaddr[PAGE_BITS-1:0],
                           tlb_update_paddr[PAGE_BITS-1:0]};

  // --------------------------------------------------------------------------
  // Statistics counters
  // --------------------------------------------------------------------------
`ifdef IOTLB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;
  logic [CNT_W-1:0] r_fill_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_fill_cnt <= '0;
    end else if (stats_clear) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_fill_cnt <= '0;
    end else begin
      if (tlb_hit && (r_hit_cnt != CNT_MAX))
        r_hit_cnt <= r_hit_cnt + 1'b1;
      if (tlb_query_valid && !tlb_hit && (r_miss_cnt != CNT_MAX))
        r_miss_cnt <= r_miss_cnt + 1'b1;
      if (w_fill && (r_fill_cnt != CNT_MAX))
        r_fill_cnt <= r_fill_cnt + 1'b1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
  assign fill_count = r_fill_cnt;
`else
  localparam int UNUSED_CNT_W = CNT_W;
  logic [31:0] w_unused_cnt_w;
  assign w_unused_cnt_w = 32'(UNUSED_CNT_W);
`endif

endmodule
`default_nettype wire
